// File: rtl/result_collector_pkg.sv
// Shared sizing, FSM encoding and address helpers for the result collector.
package result_collector_pkg;
  localparam int DATA_WIDTH  = 16;
  localparam int BUS_WIDTH   = 64;
  localparam int SP_NTARGETS = 4;
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
  localparam int SEL_W       = $clog2(SP_NTARGETS);
  localparam int ROW_W       = $clog2(MAX_DIM);
  localparam int ADDR_W      = $clog2(SP_NTARGETS * MAX_DIM);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FILL    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] mk_addr(logic [SEL_W-1:0] sel, logic [ROW_W-1:0] row);
    return {sel, row};
  endfunction

  function automatic logic [SEL_W-1:0] addr_buf(logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:ROW_W];
  endfunction

  function automatic logic [ROW_W-1:0] addr_row(logic [ADDR_W-1:0] addr);
    return addr[ROW_W-1:0];
  endfunction
endpackage

// File: rtl/result_collector_row_mask.sv
// Zeroes every element of a result row whose column index exceeds dim_m.
module result_row_mask
  import result_collector_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int bus_width  = BUS_WIDTH
) (
  input  logic [bus_width-1:0] row_in,
  input  logic [1:0]           dim_m,
  output logic [bus_width-1:0] row_out
);
  localparam int ncol = bus_width / data_width;

  for (genvar k = 0; k < ncol; k++) begin : g_col
    assign row_out[k*data_width +: data_width] =
      (k <= int'(dim_m)) ? row_in[k*data_width +: data_width] : '0;
  end
endmodule

// File: rtl/result_collector.sv
// Captures systolic-array result rows into scratchpad buffers, zero-fills
// unused rows, and serves registered reads of any buffer row.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int data_width  = DATA_WIDTH,
  parameter int bus_width   = BUS_WIDTH,
  parameter int sp_ntargets = SP_NTARGETS,
  localparam int max_dim    = bus_width / data_width,
  localparam int sel_w      = $clog2(sp_ntargets),
  localparam int row_w      = $clog2(max_dim),
  localparam int addr_w     = $clog2(sp_ntargets * max_dim)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [sel_w-1:0]     sp_sel,
  input  logic [1:0]           dim_n,
  input  logic [1:0]           dim_m,
  input  logic                 res_valid,
  input  logic [bus_width-1:0] res_row,
  input  logic                 res_last,
  input  logic                 rd_en,
  input  logic [addr_w-1:0]    rd_addr,
  output logic [bus_width-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int nrows = sp_ntargets * max_dim;

  state_t                state_q;
  logic [row_w-1:0]      row_cnt_q;
  logic [sel_w-1:0]      sel_q;
  logic [1:0]            dim_n_q, dim_m_q;
  logic                  busy_q, done_q, err_q;

  logic [nrows-1:0][bus_width-1:0] mem_q, mem_d;
  logic [bus_width-1:0]  rd_data_q, rd_data_d;

  logic [bus_width-1:0]  masked_row;
  logic [bus_width-1:0]  wr_data;
  logic [addr_w-1:0]     wr_addr;
  logic                  wr_en;
  logic                  last_row, fill_end;

  result_row_mask #(.data_width(data_width), .bus_width(bus_width)) u_mask (
    .row_in  (res_row),
    .dim_m   (dim_m_q),
    .row_out (masked_row)
  );

  assign last_row = (int'(row_cnt_q) == int'(dim_n_q));
  assign fill_end = (int'(row_cnt_q) == max_dim - 1);
  assign wr_addr  = {sel_q, row_cnt_q};

  always_comb begin
    wr_en   = 1'b0;
    wr_data = masked_row;
    if (state_q == ST_COLLECT && res_valid) begin
      wr_en = 1'b1;
    end else if (state_q == ST_FILL) begin
      wr_en   = 1'b1;
      wr_data = '0;
    end
  end

  // Reads see mem_q, so a read colliding with a write returns the old row.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
    rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q     <= '0;
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      row_cnt_q <= '0;
      sel_q     <= '0;
      dim_n_q   <= '0;
      dim_m_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_COLLECT;
            sel_q     <= sp_sel;
            dim_n_q   <= dim_n;
            dim_m_q   <= dim_m;
            row_cnt_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
          end else if (res_valid) begin
            err_q <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (res_valid) begin
            if (last_row) begin
              if (!res_last) err_q <= 1'b1;
              if (fill_end) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q   <= ST_FILL;
                row_cnt_q <= row_cnt_q + 1'b1;
              end
            end else begin
              // Early res_last truncates the stream; remaining rows get zeroed.
              if (res_last) begin
                err_q   <= 1'b1;
                state_q <= ST_FILL;
              end
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (res_valid) err_q <= 1'b1;
          if (fill_end) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            row_cnt_q <= row_cnt_q + 1'b1;
          end
        end
        default: begin
          if (res_valid) err_q <= 1'b1;
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
endmodule

// File: tb/tb_result_collector.sv
// Randomized + directed bench for result_collector against a buffer-level model.
module tb_result_collector;
  import result_collector_pkg::*;

  localparam int NADDR = SP_NTARGETS * MAX_DIM;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [SEL_W-1:0]     sp_sel;
  logic [1:0]           dim_n, dim_m;
  logic                 res_valid;
  logic [BUS_WIDTH-1:0] res_row;
  logic                 res_last;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [BUS_WIDTH-1:0] rd_data;
  logic                 busy, done, err;

  int total = 0;
  int bad   = 0;
  logic [BUS_WIDTH-1:0] mdl [NADDR];

  always #5 clk = ~clk;

  result_collector dut (
    .clk(clk), .reset(reset), .start(start), .sp_sel(sp_sel),
    .dim_n(dim_n), .dim_m(dim_m), .res_valid(res_valid), .res_row(res_row),
    .res_last(res_last), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Columns 0..m survive, the rest read back as zero.
  function automatic logic [BUS_WIDTH-1:0] col_mask(input int m);
    logic [BUS_WIDTH-1:0] one = 1;
    if ((m + 1) * DATA_WIDTH >= BUS_WIDTH) return '1;
    return (one << ((m + 1) * DATA_WIDTH)) - one;
  endfunction

  task automatic rd_chk(input int a, input logic [BUS_WIDTH-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(a);
    step();
    rd_en = 1'b0;
    chk($sformatf("rd_addr%0d", a), rd_data, exp);
  endtask

  task automatic rd_all();
    for (int a = 0; a < NADDR; a++) rd_chk(a, mdl[a]);
  endtask

  // One capture: rows stop at row n or at res_last, whichever comes first.
  // last_at > n means res_last never arrives.
  task automatic capture(input int sel, input int n, input int m, input int last_at,
                         input bit rd0, input bit st_mid, input bit ones);
    logic [BUS_WIDTH-1:0] rows [MAX_DIM];
    logic [BUS_WIDTH-1:0] old0;
    int e, cyc;
    for (int r = 0; r < MAX_DIM; r++) rows[r] = ones ? '1 : {$urandom, $urandom};
    e    = (last_at < n) ? last_at : n;
    old0 = mdl[sel*MAX_DIM];
    start = 1'b1; sp_sel = SEL_W'(sel); dim_n = 2'(n); dim_m = 2'(m);
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int r = 0; r <= e; r++) begin
      res_valid = 1'b1;
      res_row   = rows[r];
      res_last  = (r == last_at);
      if (rd0 && r == 0) begin
        rd_en   = 1'b1;
        rd_addr = mk_addr(SEL_W'(sel), '0);
      end
      if (st_mid && r == 1) begin
        start = 1'b1; sp_sel = SEL_W'(sel ^ 1); dim_n = 2'd0; dim_m = 2'd0;
      end
      step();
      res_valid = 1'b0; res_last = 1'b0; rd_en = 1'b0; start = 1'b0;
      if (rd0 && r == 0) chk("rd_same_cycle_old", rd_data, old0);
    end
    for (int r = 0; r < MAX_DIM; r++)
      mdl[sel*MAX_DIM + r] = (r <= e) ? (rows[r] & col_mask(m)) : '0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 10) begin
      step();
      cyc++;
    end
    chk("done_latency", 64'(cyc), 64'(MAX_DIM - 1 - e));
    chk("err_after_capture", 64'(err), 64'(last_at != n));
    chk("busy_at_done", 64'(busy), 64'd0);
    step();
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sp_sel = '0; dim_n = '0; dim_m = '0;
    res_valid = 1'b0; res_row = '0; res_last = 1'b0; rd_en = 1'b0; rd_addr = '0;
    for (int a = 0; a < NADDR; a++) mdl[a] = '0;
    repeat (2) step();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rd_data", rd_data, '0);
    rd_all();

    capture(1, 3, 3, 3, 1'b0, 1'b0, 1'b0);
    rd_all();
    step();
    chk("rd_data_hold", rd_data, mdl[NADDR-1]);

    capture(2, 1, 1, 1, 1'b0, 1'b0, 1'b1);
    rd_chk(8, 64'h0000_0000_FFFF_FFFF);
    rd_chk(9, 64'h0000_0000_FFFF_FFFF);
    rd_chk(10, 64'h0);
    rd_chk(11, 64'h0);

    // Row presented while idle must be dropped and flagged.
    res_valid = 1'b1; res_row = {$urandom, $urandom};
    step();
    res_valid = 1'b0;
    chk("idle_drop_err", 64'(err), 64'd1);
    rd_all();

    capture(0, 3, 2, 1, 1'b0, 1'b0, 1'b0);
    rd_all();

    capture(1, 3, 3, 3, 1'b1, 1'b0, 1'b0);
    rd_all();

    capture(3, 3, 1, 3, 1'b0, 1'b1, 1'b0);
    rd_all();

    for (int i = 0; i < 12; i++) begin
      capture($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      rd_all();
    end

    // Reset in the middle of a capture wipes everything without a done pulse.
    start = 1'b1; sp_sel = 2'd2; dim_n = 2'd3; dim_m = 2'd3;
    step();
    start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      res_valid = 1'b1; res_row = {$urandom, $urandom};
      step();
    end
    res_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int a = 0; a < NADDR; a++) mdl[a] = '0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    for (int c = 0; c < 6; c++) begin
      chk("midrst_no_done", 64'(done), 64'd0);
      step();
    end
    rd_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
